// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle for uart_rx: serial line in, received byte and strobes out.
// master is the receiver; slave is whatever drives the line and consumes the bytes.
interface uart_rx_if;
    logic       rx;
    logic [7:0] po_data;
    logic       po_flag;
    logic       frame_err;

    modport master (
        input  rx,
        output po_data,
        output po_flag,
        output frame_err
    );

    modport slave (
        output rx,
        input  po_data,
        input  po_flag,
        input  frame_err
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 3-flop synchroniser, start-edge detect, mid-bit sampling at HALF,
// one-cycle po_flag on a good stop bit or frame_err on a low stop bit.
module uart_rx #(
    parameter int unsigned UART_BPS = 9600,
    parameter int unsigned CLK_FREQ = 50_000_000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    uart_rx_if.master bus
);

    localparam int unsigned BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
    localparam int unsigned HALF         = BAUD_CNT_MAX / 2;
    localparam logic [15:0] BAUD_LAST    = 16'(BAUD_CNT_MAX - 1);
    localparam logic [15:0] HALF_V       = 16'(HALF);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t      state_q, state_d;
    logic        r1_q, r2_q, r3_q;
    logic [15:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  po_data_q, po_data_d;
    logic        po_flag_q, po_flag_d;
    logic        frame_err_q, frame_err_d;

    logic start_edge;
    logic sample_pt;

    assign start_edge = ~r2_q & r3_q;
    assign sample_pt  = (state_q != IDLE) && (baud_cnt_q == HALF_V);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= IDLE;
            r1_q        <= 1'b1;
            r2_q        <= 1'b1;
            r3_q        <= 1'b1;
            baud_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            po_data_q   <= '0;
            po_flag_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            r1_q        <= bus.rx;
            r2_q        <= r1_q;
            r3_q        <= r2_q;
            baud_cnt_q  <= baud_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            po_data_q   <= po_data_d;
            po_flag_q   <= po_flag_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Leaving STOP at the stop-bit midpoint lets a back-to-back start edge be caught.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start_edge) state_d = START;
            START: if (sample_pt)  state_d = r3_q ? IDLE : DATA;
            DATA:  if (sample_pt && (bit_cnt_q == 3'd7)) state_d = STOP;
            STOP:  if (sample_pt)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        baud_cnt_d  = baud_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        po_data_d   = po_data_q;
        po_flag_d   = 1'b0;
        frame_err_d = 1'b0;

        if (state_q == IDLE) begin
            baud_cnt_d = '0;
        end else if (baud_cnt_q == BAUD_LAST) begin
            baud_cnt_d = '0;
        end else begin
            baud_cnt_d = baud_cnt_q + 16'd1;
        end

        case (state_q)
            START: begin
                if (sample_pt && !r3_q) bit_cnt_d = '0;
            end
            DATA: begin
                if (sample_pt) begin
                    shift_d[bit_cnt_q] = r3_q;
                    bit_cnt_d          = bit_cnt_q + 3'd1;
                end
            end
            STOP: begin
                if (sample_pt) begin
                    if (r3_q) begin
                        po_data_d = shift_q;
                        po_flag_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign bus.po_data   = po_data_q;
    assign bus.po_flag   = po_flag_q;
    assign bus.frame_err = frame_err_q;

endmodule
